dff_share_arbiter: RTL and testbench
====================================

Name: dff_share_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit bank of D flip-flops (the shared register, output q) among N requesters. Each cycle it grants at most one requester. That requester's data is written into the shared register. A requester may lock the grant for a bounded burst of up to MAX_HOLD consecutive writes. It sits directly in front of the d_ff storage and is the only writer to it.

Parameters:
N, 4, number of requesters (2..16)
WIDTH, 8, data / shared-register width
MAX_HOLD, 4, max consecutive cycles one locked owner may keep the grant (>=1)
RESET_VAL, 0, value loaded into q on reset

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
req  input  N  per-requester write request
lock  input  N  per-requester burst lock; only meaningful while that requester owns the grant
wdata  input  N*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
gnt  output  N  registered one-hot grant (all-zero when idle)
gnt_valid  output  1  OR of gnt
gnt_id  output  clog2(N)  index of granted requester; holds its last value when idle
q  output  WIDTH  shared register contents
wr_cnt  output  16  count of completed writes, wraps at 0xFFFF->0x0000

Behaviour:
- Reset (rst_n=0 at an edge; synchronous only):
  - gnt=0, gnt_valid=0, gnt_id=0, q=RESET_VAL, wr_cnt=0.
  - Internal: round-robin pointer ptr=0, hold_cnt=0.
  - Reset overrides every other event in the same edge.
- Internal state: ptr (next highest-priority index), hold_cnt (0..MAX_HOLD-1).
- Write rule: at an edge where gnt[i]=1 and req[i]=1:
  - q <= wdata[i].
  - wr_cnt <= wr_cnt+1.
  - If gnt[i]=1 but req[i]=0, there is no write.
- Next-grant decision at every edge, with i the current owner:
  - KEEP if gnt[i]=1, req[i]=1, lock[i]=1 and hold_cnt < MAX_HOLD-1. Result: gnt unchanged, hold_cnt+1.
  - Otherwise ARBITRATE:
    - Search req from ptr upward, wrapping modulo N.
    - The first asserted index j wins: gnt <= onehot(j), gnt_id <= j, ptr <= (j+1) mod N, hold_cnt <= 0.
    - If no req is asserted: gnt <= 0, ptr unchanged, hold_cnt <= 0.
- Fairness:
  - After a grant, ptr moves past the winner, so the previous owner has lowest priority.
  - If the previous owner is the only requester, it is re-granted immediately with hold_cnt=0. No idle bubble.
- Timing:
  - req[i] sampled high at edge k (grant free) -> gnt[i]=1 after edge k.
  - The write happens at edge k+1, so q is visible after k+1.
  - Without lock, each grant lasts exactly one cycle.
- Release:
  - If the owner drops req or lock, the new winner's grant appears at that same edge. No dead cycle.
  - hold_cnt saturation forces ARBITRATE even if lock stays high.
  - A locked owner therefore writes at most MAX_HOLD consecutive times.
- MAX_HOLD=1: lock has no effect.
- lock without req is ignored. lock of a non-owner is ignored.
- X-free: q changes only on a write edge or reset.

Test Plan:
(N=4, WIDTH=8, MAX_HOLD=4, RESET_VAL=0)
1. Reset: rst_n=0 for 2 edges with req=4'b1111 and wdata all 0xFF -> gnt=0, q=0x00, wr_cnt=0 throughout. First edge after release -> gnt=4'b0001, gnt_id=0.
2. Single request: only req[2]=1, wdata2=0xA5, lock=0, from edge k -> gnt=4'b0100 after k, q=0xA5 after k+1. Requester 2 is re-granted every cycle, wr_cnt increments every edge from k+1.
3. Round robin: req=4'b1111, lock=0, wdata_i=0x10+i -> grant sequence 0,1,2,3,0 one cycle each. q follows 0x10,0x11,0x12,0x13 one cycle behind.
4. Burst cap: req=4'b1111, lock[1]=1 held, requester 1 granted -> gnt=4'b0010 for exactly 4 cycles, then the order is 2,3,0,1. q holds wdata1 over 4 writes.
5. Early release: locked owner 1 drops req after 2 grant cycles with req[3]=1 -> gnt=4'b1000 at the very next edge, no gnt=0 cycle. wr_cnt counts 2 writes from owner 1.
6. Mid-burst reset: rst_n=0 for one edge during hold_cnt=2 -> gnt=0, q=0x00, wr_cnt=0 after that edge. The next grant starts search at index 0.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// Purpose : round-robin arbiter sharing one WIDTH-bit register (q) among N writers, with bounded lock bursts.
// Latency : req sampled at edge k -> gnt after k; the granted write lands in q at edge k+1.
// Backpr. : losers simply keep req high; a locked owner keeps the grant for at most MAX_HOLD writes.
//
// Ports:
//   clk, rst_n   rising-edge clock, synchronous active-low reset
//   req, lock    per-requester write request / burst lock (lock only counts for the current owner)
//   wdata        requester i data on bits [i*WIDTH +: WIDTH]
//   gnt          registered one-hot grant (zero when idle); gnt_valid = |gnt
//   gnt_id       index of granted requester, holds last value while idle
//   q            shared register contents
//   wr_cnt       count of completed writes, wraps at 16 bits
module dff_share_arbiter #(
  parameter int                 N         = 4,
  parameter int                 WIDTH     = 8,
  parameter int                 MAX_HOLD  = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            lock,
  input  logic [N*WIDTH-1:0]      wdata,
  output logic [N-1:0]            gnt,
  output logic                    gnt_valid,
  output logic [$clog2(N)-1:0]    gnt_id,
  output logic [WIDTH-1:0]        q,
  output logic [15:0]             wr_cnt
);

  localparam int IDW = $clog2(N);
  // hold_cnt needs at least one bit even when MAX_HOLD=1
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [IDW-1:0] ptr, ptr_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt;
  logic [IDW-1:0] win;
  logic           found;
  logic           wr_en;
  logic           keep;

  // (base + off) mod N without relying on N being a power of two
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  assign gnt_valid = |gnt;

  always_comb begin
    wr_en      = |(gnt & req);
    keep       = 1'b0;
    found      = 1'b0;
    win        = '0;
    gnt_nxt    = '0;
    gnt_id_nxt = gnt_id;
    ptr_nxt    = ptr;
    hold_nxt   = '0;

    // gnt is one-hot, so gnt_id names the owner whenever wr_en is set
    if (wr_en && lock[gnt_id] && (int'(hold_cnt) < MAX_HOLD - 1)) begin
      keep = 1'b1;
    end

    // first asserted request at or after ptr, wrapping
    for (int k = 0; k < N; k++) begin
      if (!found && req[wrap_idx(ptr, k)]) begin
        found = 1'b1;
        win   = wrap_idx(ptr, k);
      end
    end

    if (keep) begin
      gnt_nxt  = gnt;
      hold_nxt = hold_cnt + HW'(1);
    end else if (found) begin
      gnt_nxt    = N'(1) << win;
      gnt_id_nxt = win;
      ptr_nxt    = (win == IDW'(N - 1)) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= RESET_VAL;
      wr_cnt   <= '0;
    end else begin
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      if (wr_en) begin
        q      <= wdata[int'(gnt_id)*WIDTH +: WIDTH];
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
module tb_dff_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  wd [4];
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic [7:0]  q;
  logic [15:0] wr_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb wdata = {wd[3], wd[2], wd[1], wd[0]};

  dff_share_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4), .RESET_VAL(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id),
    .q        (q),
    .wr_cnt   (wr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic [7:0] qv, input logic [15:0] cnt);
    chk({tag, ".gnt"},       32'(gnt),       32'(g));
    chk({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|g));
    chk({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
    chk({tag, ".q"},         32'(q),         32'(qv));
    chk({tag, ".wr_cnt"},    32'(wr_cnt),    32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    for (int i = 0; i < 4; i++) wd[i] = 8'hFF;

    // 1. reset held for two edges with everyone requesting
    tick(); expect_state("rst_e1", 4'b0000, 2'd0, 8'h00, 16'd0);
    tick(); expect_state("rst_e2", 4'b0000, 2'd0, 8'h00, 16'd0);
    rst_n = 1'b1;
    tick(); expect_state("rst_rel", 4'b0001, 2'd0, 8'h00, 16'd0);

    // 2. single requester 2, re-granted every cycle
    req = 4'b0100; wd[2] = 8'hA5;
    tick(); expect_state("single_k",  4'b0100, 2'd2, 8'h00, 16'd0);
    tick(); expect_state("single_k1", 4'b0100, 2'd2, 8'hA5, 16'd1);
    tick(); expect_state("single_k2", 4'b0100, 2'd2, 8'hA5, 16'd2);

    // 3. round robin after a fresh reset
    rst_n = 1'b0;
    tick(); expect_state("rr_rst", 4'b0000, 2'd0, 8'h00, 16'd0);
    rst_n = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) wd[i] = 8'h10 + 8'(i);
    tick(); expect_state("rr_0",  4'b0001, 2'd0, 8'h00, 16'd0);
    tick(); expect_state("rr_1",  4'b0010, 2'd1, 8'h10, 16'd1);
    tick(); expect_state("rr_2",  4'b0100, 2'd2, 8'h11, 16'd2);
    tick(); expect_state("rr_3",  4'b1000, 2'd3, 8'h12, 16'd3);
    tick(); expect_state("rr_0b", 4'b0001, 2'd0, 8'h13, 16'd4);

    // 4. burst cap: requester 1 locks, keeps the grant for exactly 4 cycles
    lock = 4'b0010;
    tick(); expect_state("cap_g1", 4'b0010, 2'd1, 8'h10, 16'd5);
    tick(); expect_state("cap_g2", 4'b0010, 2'd1, 8'h11, 16'd6);
    tick(); expect_state("cap_g3", 4'b0010, 2'd1, 8'h11, 16'd7);
    tick(); expect_state("cap_g4", 4'b0010, 2'd1, 8'h11, 16'd8);
    tick(); expect_state("cap_r2", 4'b0100, 2'd2, 8'h11, 16'd9);
    tick(); expect_state("cap_r3", 4'b1000, 2'd3, 8'h12, 16'd10);
    tick(); expect_state("cap_r0", 4'b0001, 2'd0, 8'h13, 16'd11);
    tick(); expect_state("cap_r1", 4'b0010, 2'd1, 8'h10, 16'd12);

    // 5. early release: owner 1 drops req after two grant cycles, 3 takes over with no bubble
    req = 4'b1010; wd[1] = 8'h77;
    tick(); expect_state("rel_h1", 4'b0010, 2'd1, 8'h77, 16'd13);
    tick(); expect_state("rel_h2", 4'b0010, 2'd1, 8'h77, 16'd14);
    req = 4'b1000;
    tick(); expect_state("rel_to3", 4'b1000, 2'd3, 8'h77, 16'd14);
    tick(); expect_state("rel_3w",  4'b1000, 2'd3, 8'h13, 16'd15);

    // 6. reset in the middle of a locked burst (hold_cnt=2)
    req = 4'b1111; lock = 4'b0010;
    tick(); expect_state("mid_g0", 4'b0001, 2'd0, 8'h13, 16'd16);
    tick(); expect_state("mid_g1", 4'b0010, 2'd1, 8'h10, 16'd17);
    tick(); expect_state("mid_h1", 4'b0010, 2'd1, 8'h77, 16'd18);
    tick(); expect_state("mid_h2", 4'b0010, 2'd1, 8'h77, 16'd19);
    rst_n = 1'b0;
    tick(); expect_state("mid_rst", 4'b0000, 2'd0, 8'h00, 16'd0);
    rst_n = 1'b1;
    tick(); expect_state("mid_post0", 4'b0001, 2'd0, 8'h00, 16'd0);
    tick(); expect_state("mid_post1", 4'b0010, 2'd1, 8'h10, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
